// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Provides the button FSM state encoding and a constant-safe clog2.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus debounce counter for an active-low switch.
// Ports: clk, rst (sync, active-high), din_n (raw async), stable_n (debounced).
module sync_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic din_n,
    output logic stable_n
);

    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1_n;
    logic          r_sync2_n;
    logic          r_stable_n;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_n  <= 1'b1;
            r_sync2_n  <= 1'b1;
            r_stable_n <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_sync1_n <= din_n;
            r_sync2_n <= r_sync1_n;
            // Any cycle of agreement restarts the run, so short
            // glitches never reach the terminal count.
            if (r_sync2_n == r_stable_n) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable_n <= r_sync2_n;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable_n = r_stable_n;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: sync + debounce, then press/release/long-press events.
// Ports: clk, rst (sync, active-high), btn_n (raw, active-low) ->
//   pressed (debounced level), press_pulse, release_pulse, long_pulse (1-cycle).
// Build option: define AUTOREPEAT_EN to repeat long_pulse every REPEAT_CYCLES while held.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int REPEAT_CYCLES   = 5400000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int HW = clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_conditioner: cycle parameters out of range");
    end

    logic          w_stable_n;
    btn_state_t    r_state;
    logic [HW-1:0] r_hold_cnt;
    logic          r_pressed;
    logic          r_press_pulse;
    logic          r_release_pulse;
    logic          r_long_pulse;

`ifdef AUTOREPEAT_EN
    localparam int RW = clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] r_rep_cnt;
`endif

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk     (clk),
        .rst     (rst),
        .din_n   (btn_n),
        .stable_n(w_stable_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_hold_cnt      <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
`ifdef AUTOREPEAT_EN
            r_rep_cnt       <= '0;
`endif
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_pressed       <= ~w_stable_n;
            unique case (r_state)
                IDLE: begin
                    if (!w_stable_n) begin
                        r_state       <= PRESSED;
                        r_press_pulse <= 1'b1;
                        r_hold_cnt    <= '0;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over the long event.
                    if (w_stable_n) begin
                        r_state         <= IDLE;
                        r_release_pulse <= 1'b1;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state      <= HELD;
                        r_long_pulse <= 1'b1;
                        // Parks at LONG_CYCLES and stays there while HELD.
                        r_hold_cnt   <= r_hold_cnt + 1'b1;
`ifdef AUTOREPEAT_EN
                        r_rep_cnt    <= '0;
`endif
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (w_stable_n) begin
                        r_state         <= IDLE;
                        r_release_pulse <= 1'b1;
                    end
`ifdef AUTOREPEAT_EN
                    else if (r_rep_cnt == REP_LAST) begin
                        r_long_pulse <= 1'b1;
                        r_rep_cnt    <= '0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;

endmodule
